ps2_keyb_rx: RTL and testbench
==============================

Name: ps2_keyb_rx

Overview:
- PS/2 keyboard front end for the Videopac keyboard path. Sits directly upstream of vp_keymap.
- Synchronises and filters the raw PS/2 clock and data lines, then deserialises 11-bit frames.
- Resolves the E0/F0/E1 prefix sequences and translates set-2 scancodes to the 8-bit key codes that vp_keymap consumes.
- Presents one key event at a time on the rx_data_ready/rx_ascii/rx_released handshake.

Parameters:
- FILTER_LEN, 4: number of consecutive equal synchronised ps2_clk samples needed to change the filtered clock.
- TIMEOUT_CYC, 20000: clk_i cycles without a sample strobe, mid-frame, before the frame is aborted.

Ports:
- clk_i  in  1  system clock
- res_i  in  1  synchronous reset, active-high
- ps2_clk_i  in  1  raw PS/2 clock line
- ps2_data_i  in  1  raw PS/2 data line
- rx_data_ready_o  out  1  key event pending
- rx_ascii_o  out  8  translated key code
- rx_released_o  out  1  event is a key release (F0 seen)
- rx_extended_o  out  1  event had the E0 prefix
- rx_read_i  in  1  consumer acknowledge, one-cycle pulse
- rx_overrun_o  out  1  event lost while one was pending; sticky
- frame_err_o  out  1  one-cycle pulse on parity, stop or timeout error

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE, prefix flags and skip counter clear, filter and sync registers load 1.
- Input conditioning:
  - Two-FF synchroniser on each PS/2 line.
  - Filtered clock goes to 0 when the last FILTER_LEN synced samples are all 0, and to 1 when they are all 1; otherwise it holds.
  - A strobe is the filtered clock's 1->0 transition. The synced data bit is captured on the strobe cycle.
- Frame FSM (advances only on strobe):
  - IDLE: data=0 -> DATA with bitcnt=0; data=1 -> stay.
  - DATA: shift data in LSB first; after bitcnt=7 -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if data=1 and the 9 bits (data + parity) hold an odd number of ones, byte_valid pulses. Otherwise frame_err_o pulses. Either way -> IDLE.
- Timeout:
  - The counter clears on every strobe and in IDLE.
  - When the counter reaches TIMEOUT_CYC outside IDLE: -> IDLE, frame_err_o pulse, partial byte discarded.
- Prefix stage (acts on byte_valid; the byte is registered in stage 1):
  - E0: set ext_flag.
  - F0: set rel_flag.
  - E1: set skip=7; the next 7 bytes are discarded silently.
  - AA, FA, FE, EE, 00, FF: ignored, flags unchanged.
  - Any other byte: look up code=map(byte, ext_flag).
    - If code != 00, emit an event with the current ext_flag and rel_flag.
    - In both cases clear ext_flag and rel_flag.
  - A frame error does not clear the flags.
- Latency: rx_data_ready_o rises exactly 2 clk_i cycles after the STOP-bit strobe cycle (stage 1 byte register, stage 2 output registers).
- Output handshake:
  - An event loads rx_ascii_o, rx_released_o and rx_extended_o, and sets ready, if ready=0 or rx_read_i=1 in the same cycle.
  - If ready=1 and rx_read_i=0, the new event is dropped, the held event stays unchanged, and rx_overrun_o=1.
  - rx_read_i with ready=1 and no new event: ready=0 and rx_overrun_o=0 on the next cycle.
  - rx_read_i with ready=0: no effect.
  - Outputs hold stable while ready=1.
- Reset mid-frame: on the next cycle the block is idle and no event is pending. Leftover line activity is resynchronised by the start-bit rule.

Decomposition:
- Shared package vp_ps2_pkg holds:
  - Prefix constants: PS2_EXT=E0, PS2_REL=F0, PS2_PAUSE=E1.
  - Ignore-list codes.
  - FSM state encodings.
  - Key code constants: KEY_UP=80, KEY_DOWN=81, KEY_LEFT=82, KEY_RIGHT=83, KEY_ENTER=0D, KEY_SPACE=20, KEY_BS=08, KEY_ESC=1B.
- Sub-module ps2_scan2ascii: combinational (scancode, ext) -> 8-bit code, with 00 meaning unmapped.
  - Letters map to uppercase ASCII (1C->41, 32->42).
  - Digits: 45->30, 16->31.
  - Other keys: 29->20, 5A->0D.
  - Arrows (ext=1 only): 75->80, 72->81, 6B->82, 74->83.

Test Plan:
- Frame 1C, correct parity -> 2 cycles after the stop strobe: ready=1, ascii=41, rel=0, ext=0. Outputs hold for 100 cycles; a rx_read_i pulse gives ready=0 next cycle.
- Bytes F0,1C -> exactly one event: ascii=41, rel=1, ext=0. No event for F0.
- E0,75 then E0,F0,75 -> events {80, ext=1, rel=0} then {80, ext=1, rel=1}. E0,1C -> unmapped code, no event, flags cleared.
- 1C with parity flipped -> frame_err_o pulses for 1 cycle, no event. The following 32 frame -> ascii=42.
- ps2_clk_i stopped after 4 data bits for TIMEOUT_CYC+10 cycles -> one frame_err_o pulse, FSM in IDLE. The next 16 frame -> ascii=31.
- Two events (1C, 32) with no read -> ascii stays 41 and rx_overrun_o=1. A read clears both. res_i asserted mid-frame -> all outputs 0, and a fresh 29 frame -> ascii=20.

Source files
------------

// File: rtl/vp_ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receive path.
package vp_ps2_pkg;

   // Prefix bytes
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_REL    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;

   // Keyboard status/response bytes that never carry a key
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_ERR0   = 8'h00;
   localparam logic [7:0] PS2_ERR1   = 8'hFF;

   // Bytes swallowed after an E1 (pause) prefix
   localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

   // Key codes consumed by vp_keymap
   localparam logic [7:0] KEY_UP    = 8'h80;
   localparam logic [7:0] KEY_DOWN  = 8'h81;
   localparam logic [7:0] KEY_LEFT  = 8'h82;
   localparam logic [7:0] KEY_RIGHT = 8'h83;
   localparam logic [7:0] KEY_ENTER = 8'h0D;
   localparam logic [7:0] KEY_SPACE = 8'h20;
   localparam logic [7:0] KEY_BS    = 8'h08;
   localparam logic [7:0] KEY_ESC   = 8'h1B;

   // Frame receiver states
   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } ps2_state_e;

   function automatic logic is_ignored(input logic [7:0] b);
      return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
             (b == PS2_ECHO) || (b == PS2_ERR0) || (b == PS2_ERR1);
   endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Set-2 scancode to vp_keymap key code; 00 means the key is not mapped.
module ps2_scan2ascii
   import vp_ps2_pkg::*;
(
   input  logic [7:0] scancode,
   input  logic       ext,
   output logic [7:0] code
);

   // Pure lookup; E0-prefixed codes only cover the arrow cluster
   always_comb begin
      code = 8'h00;
      if (ext) begin
         case (scancode)
            8'h75:   code = KEY_UP;
            8'h72:   code = KEY_DOWN;
            8'h6B:   code = KEY_LEFT;
            8'h74:   code = KEY_RIGHT;
            default: code = 8'h00;
         endcase
      end else begin
         case (scancode)
            8'h1C: code = 8'h41; // A
            8'h32: code = 8'h42;
            8'h21: code = 8'h43;
            8'h23: code = 8'h44;
            8'h24: code = 8'h45;
            8'h2B: code = 8'h46;
            8'h34: code = 8'h47;
            8'h33: code = 8'h48;
            8'h43: code = 8'h49;
            8'h3B: code = 8'h4A;
            8'h42: code = 8'h4B;
            8'h4B: code = 8'h4C;
            8'h3A: code = 8'h4D;
            8'h31: code = 8'h4E;
            8'h44: code = 8'h4F;
            8'h4D: code = 8'h50;
            8'h15: code = 8'h51;
            8'h2D: code = 8'h52;
            8'h1B: code = 8'h53;
            8'h2C: code = 8'h54;
            8'h3C: code = 8'h55;
            8'h2A: code = 8'h56;
            8'h1D: code = 8'h57;
            8'h22: code = 8'h58;
            8'h35: code = 8'h59;
            8'h1A: code = 8'h5A; // Z
            8'h45: code = 8'h30; // 0
            8'h16: code = 8'h31;
            8'h1E: code = 8'h32;
            8'h26: code = 8'h33;
            8'h25: code = 8'h34;
            8'h2E: code = 8'h35;
            8'h36: code = 8'h36;
            8'h3D: code = 8'h37;
            8'h3E: code = 8'h38;
            8'h46: code = 8'h39; // 9
            8'h29: code = KEY_SPACE;
            8'h5A: code = KEY_ENTER;
            8'h66: code = KEY_BS;
            8'h76: code = KEY_ESC;
            default: code = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/ps2_keyb_rx.sv
// PS/2 keyboard receiver: line conditioning, frame deserialiser, prefix
// resolution and a single-entry key event output register.
module ps2_keyb_rx
   import vp_ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN  = 4,
   parameter int unsigned TIMEOUT_CYC = 20000
) (
   input  logic       clk_i,
   input  logic       res_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       rx_data_ready_o,
   output logic [7:0] rx_ascii_o,
   output logic       rx_released_o,
   output logic       rx_extended_o,
   input  logic       rx_read_i,
   output logic       rx_overrun_o,
   output logic       frame_err_o
);

   localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

   // ---------------- input conditioning ----------------
   logic                  clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
   logic [FILTER_LEN-1:0] filt_sr_q;
   logic                  clk_f_q, clk_f_d;
   logic                  strobe;

   always_comb begin
      clk_f_d = clk_f_q;
      if (filt_sr_q == '0) clk_f_d = 1'b0;
      else if (filt_sr_q == '1) clk_f_d = 1'b1;
   end

   assign strobe = clk_f_q & ~clk_f_d;

   // Two-FF synchronisers and the clock glitch filter history
   always_ff @(posedge clk_i) begin
      if (res_i) begin
         clk_s1_q  <= 1'b1;
         clk_s2_q  <= 1'b1;
         data_s1_q <= 1'b1;
         data_s2_q <= 1'b1;
         filt_sr_q <= '1;
         clk_f_q   <= 1'b1;
      end else begin
         clk_s1_q  <= ps2_clk_i;
         clk_s2_q  <= clk_s1_q;
         data_s1_q <= ps2_data_i;
         data_s2_q <= data_s1_q;
         filt_sr_q <= {filt_sr_q[FILTER_LEN-2:0], clk_s2_q};
         clk_f_q   <= clk_f_d;
      end
   end

   // ---------------- frame FSM ----------------
   ps2_state_e      state_q, state_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            byte_valid, frame_err;

   // Frame state register
   always_ff @(posedge clk_i) begin
      if (res_i) begin
         state_q  <= StIdle;
         bitcnt_q <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tmo_q    <= tmo_d;
      end
   end

   // Frame next-state: advances on strobes, aborts on a stalled clock
   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tmo_d      = tmo_q;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      if (strobe) begin
         tmo_d = '0;
         unique case (state_q)
            StIdle: begin
               if (!data_s2_q) begin
                  state_d  = StData;
                  bitcnt_d = '0;
               end
            end
            StData: begin
               shift_d  = {data_s2_q, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = StParity;
            end
            StParity: begin
               par_d   = data_s2_q;
               state_d = StStop;
            end
            StStop: begin
               if (data_s2_q && (^{shift_q, par_q})) byte_valid = 1'b1;
               else frame_err = 1'b1;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end else if (state_q == StIdle) begin
         tmo_d = '0;
      end else if (tmo_q == TmoW'(TIMEOUT_CYC)) begin
         state_d   = StIdle;
         frame_err = 1'b1;
         tmo_d     = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   // ---------------- stage 1: received byte ----------------
   logic [7:0] byte_q;
   logic       byte_vld_q;
   logic       frame_err_q;

   // Register the completed byte and the error pulse
   always_ff @(posedge clk_i) begin
      if (res_i) begin
         byte_q      <= '0;
         byte_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (byte_valid) byte_q <= shift_q;
         byte_vld_q  <= byte_valid;
         frame_err_q <= frame_err;
      end
   end

   // ---------------- prefix resolution ----------------
   logic       ext_q, ext_d, rel_q, rel_d;
   logic [2:0] skip_q, skip_d;
   logic [7:0] code;
   logic       evt;

   ps2_scan2ascii u_map (
      .scancode (byte_q),
      .ext      (ext_q),
      .code     (code)
   );

   // Prefix flags track E0/F0; E1 swallows the rest of the pause sequence
   always_comb begin
      ext_d  = ext_q;
      rel_d  = rel_q;
      skip_d = skip_q;
      evt    = 1'b0;
      if (byte_vld_q) begin
         if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
         end else if (byte_q == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (byte_q == PS2_REL) begin
            rel_d = 1'b1;
         end else if (byte_q == PS2_PAUSE) begin
            skip_d = PS2_PAUSE_SKIP;
         end else if (!is_ignored(byte_q)) begin
            evt   = (code != 8'h00);
            ext_d = 1'b0;
            rel_d = 1'b0;
         end
      end
   end

   // Prefix state register
   always_ff @(posedge clk_i) begin
      if (res_i) begin
         ext_q  <= 1'b0;
         rel_q  <= 1'b0;
         skip_q <= '0;
      end else begin
         ext_q  <= ext_d;
         rel_q  <= rel_d;
         skip_q <= skip_d;
      end
   end

   // ---------------- stage 2: event output ----------------
   logic       ready_q, ready_d, ovr_q, ovr_d, out_rel_q, out_rel_d, out_ext_q, out_ext_d;
   logic [7:0] ascii_q, ascii_d;

   // Single-entry holding register; a new event only lands once consumed
   always_comb begin
      ready_d   = ready_q;
      ovr_d     = ovr_q;
      ascii_d   = ascii_q;
      out_rel_d = out_rel_q;
      out_ext_d = out_ext_q;
      if (evt) begin
         if (!ready_q || rx_read_i) begin
            ready_d   = 1'b1;
            ascii_d   = code;
            out_rel_d = rel_q;
            out_ext_d = ext_q;
            if (rx_read_i) ovr_d = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (rx_read_i && ready_q) begin
         ready_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   // Output registers
   always_ff @(posedge clk_i) begin
      if (res_i) begin
         ready_q   <= 1'b0;
         ovr_q     <= 1'b0;
         ascii_q   <= '0;
         out_rel_q <= 1'b0;
         out_ext_q <= 1'b0;
      end else begin
         ready_q   <= ready_d;
         ovr_q     <= ovr_d;
         ascii_q   <= ascii_d;
         out_rel_q <= out_rel_d;
         out_ext_q <= out_ext_d;
      end
   end

   assign rx_data_ready_o = ready_q;
   assign rx_ascii_o      = ascii_q;
   assign rx_released_o   = out_rel_q;
   assign rx_extended_o   = out_ext_q;
   assign rx_overrun_o    = ovr_q;
   assign frame_err_o     = frame_err_q;

endmodule

// File: tb/tb_ps2_keyb_rx.sv
// Directed bench for ps2_keyb_rx: drives PS/2 frames and checks key events.
module tb_ps2_keyb_rx;

   localparam int unsigned TMO = 20000;

   logic       clk = 1'b0;
   logic       res = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rx_read = 1'b0;
   logic       rx_data_ready_o, rx_released_o, rx_extended_o, rx_overrun_o, frame_err_o;
   logic [7:0] rx_ascii_o;

   int total = 0;
   int bad   = 0;

   ps2_keyb_rx #(
      .FILTER_LEN  (4),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk_i           (clk),
      .res_i           (res),
      .ps2_clk_i       (ps2_clk),
      .ps2_data_i      (ps2_data),
      .rx_data_ready_o (rx_data_ready_o),
      .rx_ascii_o      (rx_ascii_o),
      .rx_released_o   (rx_released_o),
      .rx_extended_o   (rx_extended_o),
      .rx_read_i       (rx_read),
      .rx_overrun_o    (rx_overrun_o),
      .frame_err_o     (frame_err_o)
   );

   always #5 clk = ~clk;

   // Event / error monitor, sampled on the falling clock edge
   int   cyc = 0, ev_cnt = 0, rise_cyc = 0, err_cnt = 0, err_hi = 0;
   logic rdy_prev = 1'b0, err_prev = 1'b0;

   always @(negedge clk) begin
      cyc      <= cyc + 1;
      rdy_prev <= rx_data_ready_o;
      err_prev <= frame_err_o;
      if (rx_data_ready_o && !rdy_prev) begin
         ev_cnt   <= ev_cnt + 1;
         rise_cyc <= cyc;
      end
      if (frame_err_o) begin
         err_hi <= err_hi + 1;
         if (!err_prev) err_cnt <= err_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   int last_fall = 0;

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cyc(10);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      wait_cyc(20);
      ps2_clk = 1'b1;
      wait_cyc(10);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic flip);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ flip);
      send_bit(1'b1);
      wait_cyc(5);
   endtask

   task automatic do_read();
      @(negedge clk);
      rx_read = 1'b1;
      @(negedge clk);
      rx_read = 1'b0;
   endtask

   task automatic expect_event(input string tag, input int ev0, input logic [7:0] a,
                               input logic rel, input logic ext);
      check({tag, "_count"}, ev_cnt - ev0, 1);
      check({tag, "_ascii"}, rx_ascii_o, a);
      check({tag, "_rel"}, rx_released_o, rel);
      check({tag, "_ext"}, rx_extended_o, ext);
   endtask

   int ev0, er0, eh0;

   initial begin
      wait_cyc(5);
      res = 1'b0;
      @(negedge clk);
      check("reset_outputs", {rx_data_ready_o, rx_ascii_o, rx_released_o, rx_extended_o,
                              rx_overrun_o, frame_err_o}, 0);

      // Plain make code with latency and hold checks
      ev0 = ev_cnt;
      send_frame(8'h1C, 1'b0);
      expect_event("a_make", ev0, 8'h41, 1'b0, 1'b0);
      check("a_latency", rise_cyc - last_fall, 8);
      wait_cyc(100);
      check("a_hold", {rx_data_ready_o, rx_ascii_o, rx_released_o, rx_extended_o},
            {1'b1, 8'h41, 1'b0, 1'b0});
      do_read();
      check("a_read_ready", rx_data_ready_o, 0);

      // Release
      ev0 = ev_cnt;
      send_frame(8'hF0, 1'b0);
      check("f0_no_event", ev_cnt - ev0, 0);
      send_frame(8'h1C, 1'b0);
      expect_event("a_break", ev0, 8'h41, 1'b1, 1'b0);
      do_read();

      // Extended make and break
      ev0 = ev_cnt;
      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      expect_event("up_make", ev0, 8'h80, 1'b0, 1'b1);
      do_read();
      ev0 = ev_cnt;
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      expect_event("up_break", ev0, 8'h80, 1'b1, 1'b1);
      do_read();

      // Unmapped extended code: no event and flags cleared
      ev0 = ev_cnt;
      send_frame(8'hE0, 1'b0);
      send_frame(8'h1C, 1'b0);
      check("e0_1c_no_event", ev_cnt - ev0, 0);
      send_frame(8'h1C, 1'b0);
      expect_event("flags_cleared", ev0, 8'h41, 1'b0, 1'b0);
      do_read();

      // Parity error
      ev0 = ev_cnt; er0 = err_cnt; eh0 = err_hi;
      send_frame(8'h1C, 1'b1);
      check("par_err_pulses", err_cnt - er0, 1);
      check("par_err_width", err_hi - eh0, 1);
      check("par_no_event", ev_cnt - ev0, 0);
      send_frame(8'h32, 1'b0);
      expect_event("b_after_err", ev0, 8'h42, 1'b0, 1'b0);
      do_read();

      // Timeout after 4 data bits
      ev0 = ev_cnt; er0 = err_cnt; eh0 = err_hi;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      ps2_data = 1'b1;
      wait_cyc(TMO + 10);
      check("tmo_err_pulses", err_cnt - er0, 1);
      check("tmo_err_width", err_hi - eh0, 1);
      send_frame(8'h16, 1'b0);
      expect_event("one_after_tmo", ev0, 8'h31, 1'b0, 1'b0);
      do_read();

      // Pause sequence: E1 plus seven bytes swallowed
      ev0 = ev_cnt;
      send_frame(8'hE1, 1'b0);
      send_frame(8'h14, 1'b0);
      send_frame(8'h77, 1'b0);
      send_frame(8'hE1, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h14, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h77, 1'b0);
      check("pause_no_event", ev_cnt - ev0, 0);
      send_frame(8'h1C, 1'b0);
      expect_event("after_pause", ev0, 8'h41, 1'b0, 1'b0);
      do_read();

      // Overrun
      ev0 = ev_cnt;
      send_frame(8'h1C, 1'b0);
      send_frame(8'h32, 1'b0);
      expect_event("ovr_held", ev0, 8'h41, 1'b0, 1'b0);
      check("ovr_flag", rx_overrun_o, 1);
      do_read();
      check("ovr_read_clear", {rx_data_ready_o, rx_overrun_o}, 0);

      // Reset in the middle of a frame with an event pending
      send_frame(8'h1C, 1'b0);
      check("pre_reset_ready", rx_data_ready_o, 1);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      @(negedge clk);
      check("midframe_reset", {rx_data_ready_o, rx_ascii_o, rx_released_o, rx_extended_o,
                               rx_overrun_o, frame_err_o}, 0);
      wait_cyc(20);
      ev0 = ev_cnt;
      send_frame(8'h29, 1'b0);
      expect_event("space_after_reset", ev0, 8'h20, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
